// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encoding and the one-hot
// helper, sized for the widest supported select (6 bits -> 64 outputs).
package scan_decoder_pkg;

  localparam int unsigned MAX_SEL_W = 6;
  localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Bit k set, bit 0 is the LSB; callers truncate to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] k);
    return MAX_OUT_W'(1) << k;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for scan mode: counts enabled cycles and strobes when the
// live dwell threshold is reached, then restarts from zero.
module dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  output logic               adv_c
);

  logic [DWELL_W-1:0] count;

  // Compare against the live threshold so lowering dwell advances immediately.
  assign adv_c = !clear && !hold && (count >= dwell);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!hold) begin
      if (adv_c) count <= '0;
      else       count <= count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a DIRECT mode (decode x) and a SCAN mode
// that auto-cycles the active output, holding each index dwell+1 cycles.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter  int unsigned SEL_W      = 3,
  parameter  int unsigned DWELL_W    = 16,
  parameter  bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W      = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   x,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;
  localparam logic [SEL_W-1:0] LAST_IDX = '1;

  mode_e      prev_mode;
  logic       scan_sel;
  logic       entry;
  logic       adv_c;
  logic [SEL_W-1:0] idx_inc;

  assign scan_sel = (mode_e'(mode) == MODE_SCAN);
  assign entry    = scan_sel && (prev_mode == MODE_DIRECT);
  assign idx_inc  = idx + SEL_W'(1);

  // Decoded output pattern with polarity applied.
  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] k);
    logic [OUT_W-1:0] v;
    v = OUT_W'(onehot(MAX_SEL_W'(k)));
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // Counter restarts on any DIRECT cycle or scan entry; frozen while disabled.
  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (en && (!scan_sel || entry)),
    .hold  (!en),
    .dwell (dwell),
    .adv_c (adv_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= INACTIVE;
      idx       <= '0;
      wrap      <= 1'b0;
      prev_mode <= MODE_DIRECT;
    end else if (!en) begin
      y    <= INACTIVE;
      wrap <= 1'b0;
    end else if (!scan_sel) begin
      y         <= dec(x);
      idx       <= x;
      wrap      <= 1'b0;
      prev_mode <= MODE_DIRECT;
    end else if (entry) begin
      y         <= dec(x);
      idx       <= x;
      wrap      <= 1'b0;
      prev_mode <= MODE_SCAN;
    end else if (adv_c) begin
      y    <= dec(idx_inc);
      idx  <= idx_inc;
      wrap <= (idx == LAST_IDX);
    end else begin
      y    <= dec(idx);
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: default instance plus an active-low,
// 2-bit-select instance.
module tb_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  x = '0;
  logic [1:0]  x2 = '0;
  logic [15:0] dwell = '0;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        wrap;
  logic [3:0]  y2;
  logic [1:0]  idx2;
  logic        wrap2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  x;
    logic [15:0] dwell;
    obs_t        e;
  } stim_t;

  obs_t sb[$];

  always #5 clk = ~clk;

  scan_decoder dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x), .dwell(dwell),
    .y(y), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x(x2), .dwell(dwell),
    .y(y2), .idx(idx2), .wrap(wrap2)
  );

  function automatic stim_t mk(input logic r, input logic e, input logic m,
                               input logic [2:0] xv, input logic [15:0] dv,
                               input logic [7:0] ey, input logic [2:0] ei,
                               input logic ew);
    stim_t s;
    s.rst = r; s.en = e; s.mode = m; s.x = xv; s.dwell = dv;
    s.e = '{y: ey, idx: ei, wrap: ew};
    return s;
  endfunction

  // Drive one cycle of stimulus, queue its expected outcome, step past the edge.
  task automatic apply(input stim_t s);
    rst = s.rst; en = s.en; mode = s.mode; x = s.x; dwell = s.dwell;
    sb.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(1, 1, 0, 3'd3, 16'd0, 8'h00, 3'd0, 0));
    st.push_back(mk(1, 1, 1, 3'd5, 16'd0, 8'h00, 3'd0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_direct();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(0, 1, 0, 3'd3, 16'd0, 8'h08, 3'd3, 0));
    st.push_back(mk(0, 1, 0, 3'd7, 16'd0, 8'h80, 3'd7, 0));
    st.push_back(mk(0, 1, 0, 3'd0, 16'd0, 8'h01, 3'd0, 0));
    st.push_back(mk(0, 1, 0, 3'd5, 16'd0, 8'h20, 3'd5, 0));
    st.push_back(mk(0, 0, 0, 3'd2, 16'd0, 8'h00, 3'd5, 0));
    st.push_back(mk(0, 1, 0, 3'd2, 16'd0, 8'h04, 3'd2, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL direct[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_scan_dwell0();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(0, 1, 1, 3'd6, 16'd0, 8'h40, 3'd6, 0));
    st.push_back(mk(0, 1, 1, 3'd1, 16'd0, 8'h80, 3'd7, 0));
    st.push_back(mk(0, 1, 1, 3'd1, 16'd0, 8'h01, 3'd0, 1));
    st.push_back(mk(0, 1, 1, 3'd1, 16'd0, 8'h02, 3'd1, 0));
    st.push_back(mk(0, 1, 1, 3'd1, 16'd0, 8'h04, 3'd2, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL scan_dwell0[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  // Dwell of 2 holds each index three cycles; dropping dwell forces an advance.
  task automatic test_scan_dwell2();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(0, 1, 0, 3'd0, 16'd2, 8'h01, 3'd0, 0));
    st.push_back(mk(0, 1, 1, 3'd0, 16'd2, 8'h01, 3'd0, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h01, 3'd0, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h01, 3'd0, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h02, 3'd1, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h02, 3'd1, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h02, 3'd1, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h04, 3'd2, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd2, 8'h04, 3'd2, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd0, 8'h08, 3'd3, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd0, 8'h10, 3'd4, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL scan_dwell2[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  // Pause at idx 4 with count 1 of dwell 3; resume must need only two more holds.
  task automatic test_enable_hold();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(0, 1, 1, 3'd7, 16'd3, 8'h10, 3'd4, 0));
    for (int k = 0; k < 5; k++)
      st.push_back(mk(0, 0, (k == 2) ? 1'b0 : 1'b1, 3'd0, 16'd3, 8'h00, 3'd4, 0));
    st.push_back(mk(0, 1, 1, 3'd0, 16'd3, 8'h10, 3'd4, 0));
    st.push_back(mk(0, 1, 1, 3'd0, 16'd3, 8'h10, 3'd4, 0));
    st.push_back(mk(0, 1, 1, 3'd0, 16'd3, 8'h20, 3'd5, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL enable_hold[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_reset_midscan();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(1, 1, 1, 3'd6, 16'd0, 8'h00, 3'd0, 0));
    st.push_back(mk(0, 1, 1, 3'd2, 16'd0, 8'h04, 3'd2, 0));
    st.push_back(mk(0, 1, 1, 3'd6, 16'd0, 8'h08, 3'd3, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_midscan[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  // SCAN -> DIRECT -> SCAN re-entry loads x again, then wraps from 7.
  task automatic test_back_to_back();
    stim_t st[$];
    obs_t got, exp_v;
    st.push_back(mk(0, 1, 0, 3'd1, 16'd5, 8'h02, 3'd1, 0));
    st.push_back(mk(0, 1, 1, 3'd7, 16'd0, 8'h80, 3'd7, 0));
    st.push_back(mk(0, 1, 1, 3'd3, 16'd0, 8'h01, 3'd0, 1));
    st.push_back(mk(0, 1, 0, 3'd6, 16'd0, 8'h40, 3'd6, 0));
    foreach (st[i]) begin
      apply(st[i]);
      got = '{y: y, idx: idx, wrap: wrap};
      exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                 i, got.y, got.idx, got.wrap, exp_v.y, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_active_low();
    logic [3:0] want_y [3] = '{4'hE, 4'hF, 4'hB};
    logic [1:0] want_i [3] = '{2'd0, 2'd0, 2'd2};
    logic [1:0] xs     [3] = '{2'd0, 2'd3, 2'd2};
    logic       ens    [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      rst = 1'b0; mode = 1'b0; en = ens[i]; x2 = xs[i];
      @(posedge clk);
      #1;
      n_cmp++;
      if (y2 !== want_y[i] || idx2 !== want_i[i] || wrap2 !== 1'b0) begin
        n_bad++;
        $display("FAIL active_low[%0d]: got y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=0",
                 i, y2, idx2, wrap2, want_y[i], want_i[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_scan_dwell2();
    test_enable_hold();
    test_reset_midscan();
    test_back_to_back();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
